dmem_stall_ctrl: RTL and testbench

//  MEM-stage data-memory access controller; the source of the MEM_WB stall interface.

---
 rtl/dmem_stall_ctrl.sv | 137 +++++++++++++
 tb/tb_dmem_stall_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_stall_ctrl.sv
// dmem_stall_ctrl: MEM-stage data-memory access controller.
// Sends each load/store to a multi-cycle data memory over a req/ack
// handshake. It holds the pipeline with MemStall_o until the access completes.
// It also drives the Stall_* bundle and the load data into the MEM_WB register.
// Optional feature: define DMEM_TIMEOUT_EN to add a wait-state limit
// (TIMEOUT_CYCLES) and a sticky err_o abort flag.
module dmem_stall_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  RD_i,
    input  logic        MemtoReg_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [31:0] data_o,
    output logic        MemStall_o,
    output logic [31:0] Stall_ALU_o,
    output logic [31:0] Stall_data_o,
    output logic [4:0]  Stall_RD_o,
    output logic        Stall_MemtoReg_o,
    output logic        Stall_RegWrite_o
`ifdef DMEM_TIMEOUT_EN
    ,
    output logic        err_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;
    state_t next_state;
    logic   acc;
    logic   timeout;

    assign acc = MemRead_i | MemWrite_i;

    assign Stall_ALU_o      = mem_addr_o;
    assign Stall_data_o     = data_o;
    assign Stall_RegWrite_o = 1'b0;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    assign timeout = (state == S_WAIT) && !mem_ack_i &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count unanswered wait states; an expired limit raises the sticky error flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            if (state == S_IDLE && acc) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT && !mem_ack_i) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (timeout) begin
                err_o <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state decode; the request cycle in IDLE already stalls the pipeline
    always_comb begin
        next_state = state;
        MemStall_o = 1'b0;
        case (state)
            S_IDLE: begin
                MemStall_o = acc;
                if (acc) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                MemStall_o = 1'b1;
                if (mem_ack_i || timeout) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State register, captured request fields, registered req and load data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= S_IDLE;
            mem_req_o        <= 1'b0;
            mem_we_o         <= 1'b0;
            mem_addr_o       <= '0;
            mem_wdata_o      <= '0;
            data_o           <= '0;
            Stall_RD_o       <= '0;
            Stall_MemtoReg_o <= 1'b0;
        end else begin
            state     <= next_state;
            mem_req_o <= (next_state == S_WAIT);
            if (state == S_IDLE && acc) begin
                mem_we_o         <= MemWrite_i;
                mem_addr_o       <= addr_i;
                mem_wdata_o      <= wdata_i;
                Stall_RD_o       <= RD_i;
                Stall_MemtoReg_o <= MemtoReg_i;
            end
            if (state == S_WAIT && mem_ack_i && !mem_we_o) begin
                data_o <= mem_rdata_i;
            end else if (timeout && !mem_we_o) begin
                data_o <= 32'hDEAD_BEEF;
            end
        end
    end

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// tb_dmem_stall_ctrl: directed, table-driven bench for dmem_stall_ctrl.
// Each table row is one clock cycle of inputs plus the outputs expected in
// that cycle; hand sequences cover the request-pulse order and, with
// DMEM_TIMEOUT_EN defined, the timeout abort.
module tb_dmem_stall_ctrl;

    typedef struct {
        logic        rst;
        logic        mrd;
        logic        mwr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        m2r;
        logic        ack;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_maddr;
        logic [31:0] e_wdata;
        logic [31:0] e_data;
        logic [4:0]  e_rd;
        logic        e_m2r;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        mem_to_reg;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] data;
    logic        mem_stall;
    logic [31:0] stall_alu;
    logic [31:0] stall_data;
    logic [4:0]  stall_rd;
    logic        stall_mem_to_reg;
    logic        stall_reg_write;
`ifdef DMEM_TIMEOUT_EN
    logic        err;
`endif

    int          assert_count = 0;
    int          fail_count   = 0;
    vec_t        vecs[$];
    logic [31:0] pulse_addrs[$];
    logic [31:0] exp_pulses[6] = '{32'h40, 32'h80, 32'h10, 32'h14, 32'h44, 32'h200};
    bit          mon_on   = 0;
    logic        req_prev = 1'b0;

    dmem_stall_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .MemRead_i        (mem_read),
        .MemWrite_i       (mem_write),
        .addr_i           (addr),
        .wdata_i          (wdata),
        .RD_i             (rd),
        .MemtoReg_i       (mem_to_reg),
        .mem_ack_i        (mem_ack),
        .mem_rdata_i      (mem_rdata),
        .mem_req_o        (mem_req),
        .mem_we_o         (mem_we),
        .mem_addr_o       (mem_addr),
        .mem_wdata_o      (mem_wdata),
        .data_o           (data),
        .MemStall_o       (mem_stall),
        .Stall_ALU_o      (stall_alu),
        .Stall_data_o     (stall_data),
        .Stall_RD_o       (stall_rd),
        .Stall_MemtoReg_o (stall_mem_to_reg),
        .Stall_RegWrite_o (stall_reg_write)
`ifdef DMEM_TIMEOUT_EN
        ,
        .err_o            (err)
`endif
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Record the address of every rising edge of mem_req while enabled
    always @(negedge clk) begin
        if (mon_on) begin
            if (mem_req && !req_prev) begin
                pulse_addrs.push_back(mem_addr);
            end
            req_prev = mem_req;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst        = v.rst;
        mem_read   = v.mrd;
        mem_write  = v.mwr;
        addr       = v.addr;
        wdata      = v.wdata;
        rd         = v.rd;
        mem_to_reg = v.m2r;
        mem_ack    = v.ack;
        mem_rdata  = v.rdata;
    endtask

    task automatic addVec(input logic r, input logic mrd, input logic mwr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rdi, input logic m2r, input logic ack,
                          input logic [31:0] rdat, input logic e_stall,
                          input logic e_req, input logic e_we,
                          input logic [31:0] e_maddr, input logic [31:0] e_wdata,
                          input logic [31:0] e_data, input logic [4:0] e_rd,
                          input logic e_m2r);
        vec_t v;
        v.rst = r;  v.mrd = mrd;  v.mwr = mwr;  v.addr = a;  v.wdata = wd;
        v.rd = rdi; v.m2r = m2r;  v.ack = ack;  v.rdata = rdat;
        v.e_stall = e_stall; v.e_req = e_req; v.e_we = e_we;
        v.e_maddr = e_maddr; v.e_wdata = e_wdata; v.e_data = e_data;
        v.e_rd = e_rd; v.e_m2r = e_m2r;
        vecs.push_back(v);
    endtask

    initial begin
        // Load 0x40 -> RD5 with three WAIT cycles (4 stall cycles)
        addVec(0,1,0,32'h40,0,5,1,0,0,                  1,0,0,0,0,0,0,0);
        addVec(0,1,0,32'h40,0,5,1,0,0,                  1,1,0,32'h40,0,0,5,1);
        addVec(0,1,0,32'h999,32'h1111,9,0,0,0,          1,1,0,32'h40,0,0,5,1);
        addVec(0,1,0,32'h40,0,5,1,1,32'h12345678,       1,1,0,32'h40,0,0,5,1);
        addVec(0,1,0,32'h40,0,5,1,0,0,                  0,0,0,0,0,32'h12345678,5,1);
        addVec(0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,32'h12345678,5,1);
        // Store 0x80, acked in the first WAIT cycle; load data must not change
        addVec(0,0,1,32'h80,32'hCAFEF00D,0,0,0,0,       1,0,0,0,0,32'h12345678,5,1);
        addVec(0,0,1,32'h80,32'hCAFEF00D,0,0,1,32'h55555555,
                                                        1,1,1,32'h80,32'hCAFEF00D,32'h12345678,0,0);
        addVec(0,0,1,32'h80,32'hCAFEF00D,0,0,0,0,       0,0,0,0,0,32'h12345678,0,0);
        addVec(0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,32'h12345678,0,0);
        // Spurious ack in IDLE is ignored
        addVec(0,0,0,0,0,0,0,1,32'hFFFFFFFF,            0,0,0,0,0,32'h12345678,0,0);
        addVec(0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,32'h12345678,0,0);
        // Back-to-back loads 0x10 and 0x14, one unanswered wait each
        addVec(0,1,0,32'h10,0,1,1,0,0,                  1,0,0,0,0,32'h12345678,0,0);
        addVec(0,1,0,32'h10,0,1,1,0,0,                  1,1,0,32'h10,0,32'h12345678,1,1);
        addVec(0,1,0,32'h10,0,1,1,1,32'hAAAA0010,       1,1,0,32'h10,0,32'h12345678,1,1);
        addVec(0,1,0,32'h10,0,1,1,0,0,                  0,0,0,0,0,32'hAAAA0010,1,1);
        addVec(0,1,0,32'h14,0,2,1,0,0,                  1,0,0,0,0,32'hAAAA0010,1,1);
        addVec(0,1,0,32'h14,0,2,1,0,0,                  1,1,0,32'h14,0,32'hAAAA0010,2,1);
        addVec(0,1,0,32'h14,0,2,1,1,32'hBBBB0014,       1,1,0,32'h14,0,32'hAAAA0010,2,1);
        addVec(0,1,0,32'h14,0,2,1,0,0,                  0,0,0,0,0,32'hBBBB0014,2,1);
        addVec(0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,32'hBBBB0014,2,1);
        // Read and write both set: treated as a store
        addVec(0,1,1,32'h44,32'h0BADCAFE,3,0,0,0,       1,0,0,0,0,32'hBBBB0014,2,1);
        addVec(0,1,1,32'h44,32'h0BADCAFE,3,0,1,32'h13579BDF,
                                                        1,1,1,32'h44,32'h0BADCAFE,32'hBBBB0014,3,0);
        addVec(0,1,1,32'h44,32'h0BADCAFE,3,0,0,0,       0,0,0,0,0,32'hBBBB0014,3,0);
        addVec(0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,32'hBBBB0014,3,0);
        // Reset in the second WAIT cycle, late ack afterwards
        addVec(0,1,0,32'h200,0,7,1,0,0,                 1,0,0,0,0,32'hBBBB0014,3,0);
        addVec(0,1,0,32'h200,0,7,1,0,0,                 1,1,0,32'h200,0,32'hBBBB0014,7,1);
        addVec(1,1,0,32'h200,0,7,1,0,0,                 1,1,0,32'h200,0,32'hBBBB0014,7,1);
        addVec(0,0,0,0,0,0,0,1,32'h77777777,            0,0,0,0,0,0,0,0);
        addVec(0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,0,0,0);

        // Power-on reset
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        rd = '0; mem_to_reg = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset mem_stall",    {31'b0, mem_stall}, 0);
        checkOutput("reset mem_req",      {31'b0, mem_req}, 0);
        checkOutput("reset mem_we",       {31'b0, mem_we}, 0);
        checkOutput("reset mem_addr",     mem_addr, 0);
        checkOutput("reset mem_wdata",    mem_wdata, 0);
        checkOutput("reset data",         data, 0);
        checkOutput("reset stall_alu",    stall_alu, 0);
        checkOutput("reset stall_rd",     {27'b0, stall_rd}, 0);
        checkOutput("reset stall_m2r",    {31'b0, stall_mem_to_reg}, 0);
        checkOutput("reset stall_regwr",  {31'b0, stall_reg_write}, 0);
`ifdef DMEM_TIMEOUT_EN
        checkOutput("reset err",          {31'b0, err}, 0);
`endif
        @(posedge clk);
        #1;

        // Table-driven cycles
        mon_on = 1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("row%0d mem_stall", i), {31'b0, mem_stall}, {31'b0, vecs[i].e_stall});
            checkOutput($sformatf("row%0d mem_req", i),   {31'b0, mem_req},   {31'b0, vecs[i].e_req});
            checkOutput($sformatf("row%0d data", i),       data,       vecs[i].e_data);
            checkOutput($sformatf("row%0d stall_data", i), stall_data, vecs[i].e_data);
            checkOutput($sformatf("row%0d stall_rd", i),   {27'b0, stall_rd}, {27'b0, vecs[i].e_rd});
            checkOutput($sformatf("row%0d stall_m2r", i),  {31'b0, stall_mem_to_reg}, {31'b0, vecs[i].e_m2r});
            checkOutput($sformatf("row%0d stall_regwr", i), {31'b0, stall_reg_write}, 0);
            if (vecs[i].e_req) begin
                checkOutput($sformatf("row%0d mem_we", i),    {31'b0, mem_we}, {31'b0, vecs[i].e_we});
                checkOutput($sformatf("row%0d mem_addr", i),  mem_addr,  vecs[i].e_maddr);
                checkOutput($sformatf("row%0d stall_alu", i), stall_alu, vecs[i].e_maddr);
                if (vecs[i].e_we) begin
                    checkOutput($sformatf("row%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
                end
            end
            @(posedge clk);
            #1;
        end
        mon_on = 0;

        // Exactly one request pulse per access, in program order
        checkOutput("req pulse count", pulse_addrs.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < pulse_addrs.size()) begin
                checkOutput($sformatf("req pulse %0d addr", k), pulse_addrs[k], exp_pulses[k]);
            end
        end

`ifdef DMEM_TIMEOUT_EN
        // Load with no ack: abort after 8 WAIT cycles
        begin
            int n;
            bit done;
            n = 0;
            done = 0;
            mem_read = 1'b1; addr = 32'h300; rd = 5'd4; mem_to_reg = 1'b1; mem_ack = 1'b0;
            @(negedge clk);
            @(posedge clk);
            #1;
            while (!done && n < 40) begin
                @(negedge clk);
                if (mem_req) begin
                    n++;
                    @(posedge clk);
                    #1;
                end else begin
                    done = 1;
                end
            end
            checkOutput("timeout wait cycles", n, 8);
            checkOutput("timeout stall in done", {31'b0, mem_stall}, 0);
            checkOutput("timeout data", data, 32'hDEADBEEF);
            checkOutput("timeout err", {31'b0, err}, 1);
            @(posedge clk);
            #1 mem_read = 1'b0;
            repeat (4) @(posedge clk);
            @(negedge clk);
            checkOutput("timeout err sticky", {31'b0, err}, 1);
            checkOutput("timeout idle req", {31'b0, mem_req}, 0);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            checkOutput("timeout err cleared", {31'b0, err}, 0);
        end
`endif

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
